// File: rtl/min_clock_time_keeper.sv
// ============================================================================
// min_clock_time_keeper
//
// Purpose:
//   Receiving end of the minute clock. It synchronises the free-running min_clk
//   square wave into the clk domain and detects each rising edge. On each edge
//   it advances a wall-time counter (minutes 0..MIN_PER_HOUR-1, hours
//   0..HOUR_PER_DAY-1). It raises one-cycle hour/day rollover pulses. A
//   valid/ready set port loads a new time.
//
// Parameters:
//   SYNC_STAGES   flops in the min_clk synchronizer chain (>= 2)
//   MIN_PER_HOUR  minute modulus
//   HOUR_PER_DAY  hour modulus
//
// Ports:
//   clk        in   system clock, rising-edge logic
//   rst_n      in   synchronous reset, active low
//   min_clk    in   minute square wave, asynchronous to clk
//   set_valid  in   set request, held stable until set_ready
//   set_hh     in   hour to load
//   set_mm     in   minute to load
//   set_ready  out  set port can accept
//   set_err    out  one-cycle pulse: request out of range and rejected
//   minutes    out  current minute
//   hours      out  current hour
//   hour_tick  out  one-cycle pulse on the minute wrap
//   day_tick   out  one-cycle pulse on the day wrap
//
// Optional feature (define MIN_CLOCK_ALARM_EN):
//   alarm_hh   in   alarm hour
//   alarm_mm   in   alarm minute
//   alarm_on   in   alarm enable
//   alarm_hit  out  one-cycle pulse, one cycle after the time becomes equal
//                   to the alarm time through a count or a load
// ============================================================================
module min_clock_time_keeper #(
    parameter int SYNC_STAGES  = 2,
    parameter int MIN_PER_HOUR = 60,
    parameter int HOUR_PER_DAY = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       min_clk,
    input  logic       set_valid,
    input  logic [4:0] set_hh,
    input  logic [5:0] set_mm,
`ifdef MIN_CLOCK_ALARM_EN
    input  logic [4:0] alarm_hh,
    input  logic [5:0] alarm_mm,
    input  logic       alarm_on,
    output logic       alarm_hit,
`endif
    output logic       set_ready,
    output logic       set_err,
    output logic [5:0] minutes,
    output logic [4:0] hours,
    output logic       hour_tick,
    output logic       day_tick
);

    localparam logic [5:0] MIN_LAST  = 6'(MIN_PER_HOUR - 1);
    localparam logic [4:0] HOUR_LAST = 5'(HOUR_PER_DAY - 1);

    typedef enum logic {RUN, LOAD} state_t;

    // Modular increments. The wrap test is an equality on the last legal
    // value, so a corrupted out-of-range count keeps climbing to the field
    // width instead of being silently clamped.
    function automatic logic [5:0] next_min(input logic [5:0] m);
        return (m == MIN_LAST) ? 6'd0 : m + 6'd1;
    endfunction

    function automatic logic [4:0] next_hour(input logic [4:0] h);
        return (h == HOUR_LAST) ? 5'd0 : h + 5'd1;
    endfunction

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   hist_p1;
    logic                   edge_vld_p1;
    logic                   pending;
    logic [4:0]             latch_hh;
    logic [5:0]             latch_mm;
    logic                   in_range;
    logic                   accept;
    logic                   do_count;
    logic                   min_wrap;
    logic                   day_wrap;

    // ---- stage p0: synchronizer chain for the asynchronous min_clk ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], min_clk};
        end
    end

    // ---- stage p1: history flop and rising-edge detect ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_p1 <= 1'b0;
        end else begin
            hist_p1 <= sync_p0[SYNC_STAGES-1];
        end
    end

    assign edge_vld_p1 = sync_p0[SYNC_STAGES-1] & ~hist_p1;

    // ---- stage p2: control decode and time counter ----
    always_comb begin
        in_range = (set_hh <= HOUR_LAST) && (set_mm <= MIN_LAST);
        accept   = (state == RUN) && set_valid && set_ready && in_range;
        // An edge that arrives while a load is being accepted or performed
        // is parked in pending. It is applied in the first free RUN cycle.
        do_count = (state == RUN) && !accept && (edge_vld_p1 || pending);
        min_wrap = (minutes == MIN_LAST);
        day_wrap = min_wrap && (hours == HOUR_LAST);
    end

    // The set latch holds data only and needs no reset. It is only consumed
    // in LOAD, which is reachable only after a write.
    always_ff @(posedge clk) begin
        if (accept) begin
            latch_hh <= set_hh;
            latch_mm <= set_mm;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            set_ready <= 1'b0;
            set_err   <= 1'b0;
            hour_tick <= 1'b0;
            day_tick  <= 1'b0;
            pending   <= 1'b0;
            minutes   <= 6'd0;
            hours     <= 5'd0;
        end else begin
            set_err   <= 1'b0;
            hour_tick <= 1'b0;
            day_tick  <= 1'b0;
            case (state)
                RUN: begin
                    set_ready <= 1'b1;
                    if (set_valid && set_ready && !in_range) begin
                        set_err <= 1'b1;
                    end
                    if (accept) begin
                        state     <= LOAD;
                        set_ready <= 1'b0;
                        pending   <= pending | edge_vld_p1;
                    end else if (do_count) begin
                        // Pending plus a fresh edge collapses to a single step.
                        pending <= 1'b0;
                        minutes <= next_min(minutes);
                        if (min_wrap) begin
                            hours     <= next_hour(hours);
                            hour_tick <= 1'b1;
                            day_tick  <= day_wrap;
                        end
                    end
                end
                LOAD: begin
                    minutes   <= latch_mm;
                    hours     <= latch_hh;
                    state     <= RUN;
                    set_ready <= 1'b1;
                    if (edge_vld_p1) begin
                        pending <= 1'b1;
                    end
                end
                default: begin
                    state     <= RUN;
                    set_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef MIN_CLOCK_ALARM_EN
    logic time_upd_p3;

    // ---- stage p3: alarm compare, one cycle behind the time update ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            time_upd_p3 <= 1'b0;
            alarm_hit   <= 1'b0;
        end else begin
            time_upd_p3 <= do_count || (state == LOAD);
            alarm_hit   <= time_upd_p3 && alarm_on &&
                           (minutes == alarm_mm) && (hours == alarm_hh);
        end
    end
`endif

endmodule
